// File: rtl/max_pool_2x2_stream.sv
// Streaming 2x2 / stride-2 max-pooling over raster-ordered multi-channel pixels.
// One pooled pixel is emitted one cycle after the bottom-right pixel of each window.
module max_pool_2x2_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int CH         = 32,
    parameter int WIDTH      = 14,
    parameter int HEIGHT     = 14,
    parameter bit FP_MODE    = 1'b1,
    parameter bit RELU_EN    = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH*CH-1:0] i_data,
    input  logic                     valid_in,
    output logic [DATA_WIDTH*CH-1:0] o_data,
    output logic                     valid_out,
    output logic                     frame_done
);

    localparam int PW       = DATA_WIDTH * CH;
    localparam int CW       = $clog2(WIDTH + 1);
    localparam int RW       = $clog2(HEIGHT + 1);
    localparam int LB_DEPTH = WIDTH / 2;
    localparam int LBW      = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
    // The trailing column/row of an odd-sized map lies outside every window.
    localparam logic [CW-1:0] COL_LIM  = CW'((WIDTH / 2) * 2);
    localparam logic [RW-1:0] ROW_LIM  = RW'((HEIGHT / 2) * 2);

    logic [CW-1:0]  col;
    logic [RW-1:0]  row;
    logic [PW-1:0]  held;
    logic [PW-1:0]  hmax;
    logic [PW-1:0]  vmax;
    logic [PW-1:0]  result;
    logic [PW-1:0]  linebuf [LB_DEPTH];
    logic [LBW-1:0] lb_idx;
    logic           col_last;
    logic           row_last;
    logic           col_ok;
    logic           row_ok;

    // Returns a unless b is strictly greater, so ties keep the first operand.
    function automatic logic [DATA_WIDTH-1:0] lane_max(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic b_wins;
        if (FP_MODE) begin
            if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1])
                b_wins = a[DATA_WIDTH-1];
            else if (a[DATA_WIDTH-1])
                b_wins = (b[DATA_WIDTH-2:0] < a[DATA_WIDTH-2:0]);
            else
                b_wins = (b[DATA_WIDTH-2:0] > a[DATA_WIDTH-2:0]);
        end else begin
            b_wins = ($signed(b) > $signed(a));
        end
        return b_wins ? b : a;
    endfunction

    assign col_last = (col == COL_LAST);
    assign row_last = (row == ROW_LAST);
    assign col_ok   = (col < COL_LIM);
    assign row_ok   = (row < ROW_LIM);
    assign lb_idx   = LBW'(col >> 1);

    always_comb begin
        hmax   = '0;
        vmax   = '0;
        result = '0;
        for (int l = 0; l < CH; l++) begin
            hmax[l*DATA_WIDTH +: DATA_WIDTH] =
                lane_max(held[l*DATA_WIDTH +: DATA_WIDTH], i_data[l*DATA_WIDTH +: DATA_WIDTH]);
            vmax[l*DATA_WIDTH +: DATA_WIDTH] =
                lane_max(linebuf[lb_idx][l*DATA_WIDTH +: DATA_WIDTH], hmax[l*DATA_WIDTH +: DATA_WIDTH]);
            result[l*DATA_WIDTH +: DATA_WIDTH] =
                (RELU_EN && vmax[l*DATA_WIDTH + DATA_WIDTH - 1]) ? '0 : vmax[l*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col        <= '0;
            row        <= '0;
            held       <= '0;
            o_data     <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            if (valid_in) begin
                col <= col_last ? '0 : col + 1'b1;
                if (col_last)
                    row <= row_last ? '0 : row + 1'b1;
                if (col_last && row_last)
                    frame_done <= 1'b1;
                if (col_ok && !col[0])
                    held <= i_data;
                if (col_ok && row_ok && col[0] && row[0]) begin
                    o_data    <= result;
                    valid_out <= 1'b1;
                end
            end
        end
    end

    // Line-buffer contents need no reset: every entry is rewritten on an even row before it is read.
    always_ff @(posedge clk) begin
        if (valid_in && col_ok && row_ok && col[0] && !row[0])
            linebuf[lb_idx] <= hmax;
    end

endmodule

// File: tb/tb_max_pool_2x2_stream.sv
// Scoreboard bench for max_pool_2x2_stream: 4x4 int, 2x2 float (with/without ReLU),
// 5x5 odd-size and default 14x14x32 instances, each with its own expected-response queue.
module tb_max_pool_2x2_stream;

    typedef struct {
        logic          vo;
        logic          fd;
        logic [1023:0] d;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b1;
    int   cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic [63:0]   d44 = '0, od44;
    logic          vin44 = 1'b0, vo44, fd44;
    logic [31:0]   d22 = '0, od22f, od22r;
    logic          vin22 = 1'b0, vo22f, fd22f, vo22r, fd22r;
    logic [31:0]   d55 = '0, od55;
    logic          vin55 = 1'b0, vo55, fd55;
    logic [1023:0] ddf = '0, oddf;
    logic          vindf = 1'b0, vodf, fddf;

    exp_t q44[$], q22f[$], q22r[$], q55[$], qdf[$];

    max_pool_2x2_stream #(.DATA_WIDTH(32), .CH(2), .WIDTH(4), .HEIGHT(4), .FP_MODE(1'b0), .RELU_EN(1'b0)) u44 (
        .clk(clk), .rst(rst_n), .i_data(d44), .valid_in(vin44),
        .o_data(od44), .valid_out(vo44), .frame_done(fd44));

    max_pool_2x2_stream #(.DATA_WIDTH(32), .CH(1), .WIDTH(2), .HEIGHT(2), .FP_MODE(1'b1), .RELU_EN(1'b0)) u22f (
        .clk(clk), .rst(rst_n), .i_data(d22), .valid_in(vin22),
        .o_data(od22f), .valid_out(vo22f), .frame_done(fd22f));

    max_pool_2x2_stream #(.DATA_WIDTH(32), .CH(1), .WIDTH(2), .HEIGHT(2), .FP_MODE(1'b1), .RELU_EN(1'b1)) u22r (
        .clk(clk), .rst(rst_n), .i_data(d22), .valid_in(vin22),
        .o_data(od22r), .valid_out(vo22r), .frame_done(fd22r));

    max_pool_2x2_stream #(.DATA_WIDTH(32), .CH(1), .WIDTH(5), .HEIGHT(5), .FP_MODE(1'b0), .RELU_EN(1'b0)) u55 (
        .clk(clk), .rst(rst_n), .i_data(d55), .valid_in(vin55),
        .o_data(od55), .valid_out(vo55), .frame_done(fd55));

    max_pool_2x2_stream udf (
        .clk(clk), .rst(rst_n), .i_data(ddf), .valid_in(vindf),
        .o_data(oddf), .valid_out(vodf), .frame_done(fddf));

    task automatic check_value(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=%h want=%h", name, got, want);
        end
    endtask

    task automatic check_output(input string name, input exp_t e, input logic vo, input logic fd,
                                input logic [1023:0] d, input int lanes);
        check_value({name, "_valid_out"}, 64'(vo), 64'(e.vo));
        check_value({name, "_frame_done"}, 64'(fd), 64'(e.fd));
        check_value({name, "_cycle"}, 64'(cyc), 64'(e.cyc));
        if (e.vo)
            for (int l = 0; l < lanes; l++)
                check_value($sformatf("%s_lane%0d", name, l), 64'(d[l*32 +: 32]), 64'(e.d[l*32 +: 32]));
    endtask

    task automatic report_stray(input string name, input logic vo, input logic fd);
        total++;
        bad++;
        $display("[TB] FAIL %s_unexpected: got valid_out=%b frame_done=%b want no output", name, vo, fd);
    endtask

    always @(negedge clk) begin : mon44
        exp_t e;
        if (vo44 || fd44) begin
            if (q44.size() == 0) report_stray("u44", vo44, fd44);
            else begin e = q44.pop_front(); check_output("u44", e, vo44, fd44, 1024'(od44), 2); end
        end
    end

    always @(negedge clk) begin : mon22f
        exp_t e;
        if (vo22f || fd22f) begin
            if (q22f.size() == 0) report_stray("u22f", vo22f, fd22f);
            else begin e = q22f.pop_front(); check_output("u22f", e, vo22f, fd22f, 1024'(od22f), 1); end
        end
    end

    always @(negedge clk) begin : mon22r
        exp_t e;
        if (vo22r || fd22r) begin
            if (q22r.size() == 0) report_stray("u22r", vo22r, fd22r);
            else begin e = q22r.pop_front(); check_output("u22r", e, vo22r, fd22r, 1024'(od22r), 1); end
        end
    end

    always @(negedge clk) begin : mon55
        exp_t e;
        if (vo55 || fd55) begin
            if (q55.size() == 0) report_stray("u55", vo55, fd55);
            else begin e = q55.pop_front(); check_output("u55", e, vo55, fd55, 1024'(od55), 1); end
        end
    end

    always @(negedge clk) begin : mondf
        exp_t e;
        if (vodf || fddf) begin
            if (qdf.size() == 0) report_stray("udf", vodf, fddf);
            else begin e = qdf.pop_front(); check_output("udf", e, vodf, fddf, oddf, 32); end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            vin44 = 1'b0;
            vin22 = 1'b0;
            vin55 = 1'b0;
            vindf = 1'b0;
        end
    endtask

    // Expected window results, hand-derived from the 4x4 stimulus patterns below.
    int exp_at44[4] = '{5, 7, 13, 15};
    int pos_l0[4]   = '{5, 7, 13, 15};
    int pos_l1[4]   = '{15, 13, 7, 5};
    int neg_l0[4]   = '{0, -2, -8, -10};
    int neg_l1[4]   = '{-3, -1, 5, 7};

    // mode 0: lane0=i, lane1=15-i; mode 1: same with 3-cycle bubbles; mode 2: lane0=-i, lane1=i-8
    task automatic apply_stimulus44(input int mode, input int beats);
        exp_t e;
        for (int i = 0; i < beats; i++) begin
            @(posedge clk);
            #1;
            vin44 = 1'b1;
            if (mode == 2) d44 = {32'(i - 8), 32'(-i)};
            else           d44 = {32'(15 - i), 32'(i)};
            for (int k = 0; k < 4; k++) begin
                if (exp_at44[k] == i) begin
                    e.vo  = 1'b1;
                    e.fd  = (k == 3);
                    e.cyc = cyc + 1;
                    e.d   = '0;
                    e.d[31:0]  = (mode == 2) ? 32'(neg_l0[k]) : 32'(pos_l0[k]);
                    e.d[63:32] = (mode == 2) ? 32'(neg_l1[k]) : 32'(pos_l1[k]);
                    q44.push_back(e);
                end
            end
            if (mode == 1 && (i % 2) == 1) idle(3);
        end
    endtask

    task automatic apply_stimulus22(input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] p2,
                                    input logic [31:0] p3, input logic [31:0] want_f, input logic [31:0] want_r);
        exp_t e;
        logic [31:0] px [4];
        px = '{p0, p1, p2, p3};
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            vin22 = 1'b1;
            d22   = px[i];
        end
        e.vo  = 1'b1;
        e.fd  = 1'b1;
        e.cyc = cyc + 1;
        e.d   = 1024'(want_f);
        q22f.push_back(e);
        e.d   = 1024'(want_r);
        q22r.push_back(e);
    endtask

    task automatic apply_stimulus55();
        exp_t e;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            vin55 = 1'b1;
            d55   = 32'(i);
            if (i == 6 || i == 8 || i == 16 || i == 18) begin
                e.vo = 1'b1; e.fd = 1'b0; e.cyc = cyc + 1; e.d = 1024'(i);
                q55.push_back(e);
            end else if (i == 24) begin
                e.vo = 1'b0; e.fd = 1'b1; e.cyc = cyc + 1; e.d = '0;
                q55.push_back(e);
            end
        end
    endtask

    // Every lane rises with raster index, so each window's maximum is its bottom-right pixel.
    task automatic apply_stimulus_df(input int frames);
        exp_t e;
        for (int f = 0; f < frames; f++) begin
            for (int i = 0; i < 196; i++) begin
                @(posedge clk);
                #1;
                vindf = 1'b1;
                for (int l = 0; l < 32; l++) ddf[l*32 +: 32] = 32'(i + l * 1000);
                if (((i / 14) % 2) == 1 && ((i % 14) % 2) == 1) begin
                    e.vo = 1'b1; e.fd = (i == 195); e.cyc = cyc + 1; e.d = ddf;
                    qdf.push_back(e);
                end
            end
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_value("reset_o_data_u44", od44, 64'd0);
        check_value("reset_valid_out_u44", 64'(vo44), 64'd0);
        check_value("reset_frame_done_u44", 64'(fd44), 64'd0);
        check_value("reset_o_data_u22f", 64'(od22f), 64'd0);
        check_value("reset_o_data_u55", 64'(od55), 64'd0);
        check_value("reset_o_data_udf_nonzero", 64'(|oddf), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        apply_stimulus44(0, 16);
        apply_stimulus44(0, 16);
        apply_stimulus44(1, 16);
        apply_stimulus44(2, 16);
        idle(3);
        check_value("u44_queue_drained", 64'(q44.size()), 64'd0);

        apply_stimulus44(0, 7);
        @(posedge clk);
        #1;
        vin44 = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check_value("midreset_o_data_u44", od44, 64'd0);
        check_value("midreset_valid_out_u44", 64'(vo44), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        apply_stimulus44(0, 16);
        idle(3);
        check_value("u44_after_reset_drained", 64'(q44.size()), 64'd0);

        apply_stimulus22(32'hBF800000, 32'hC0000000, 32'hC0400000, 32'hC0800000, 32'hBF800000, 32'h00000000);
        apply_stimulus22(32'h3F800000, 32'hC0000000, 32'h40400000, 32'hBF800000, 32'h40400000, 32'h40400000);
        apply_stimulus22(32'h40000000, 32'h3F800000, 32'hC0800000, 32'h3F000000, 32'h40000000, 32'h40000000);
        apply_stimulus22(32'hC0400000, 32'hBF000000, 32'hC0000000, 32'hC0800000, 32'hBF000000, 32'h00000000);
        idle(3);
        check_value("u22f_queue_drained", 64'(q22f.size()), 64'd0);
        check_value("u22r_queue_drained", 64'(q22r.size()), 64'd0);

        apply_stimulus55();
        idle(3);
        check_value("u55_queue_drained", 64'(q55.size()), 64'd0);

        apply_stimulus_df(2);
        idle(3);
        check_value("udf_queue_drained", 64'(qdf.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
